ascon_ps_seq: RTL and testbench

Parametrised, iterative Ascon substitution layer (p_S). It operates on the 320-bit permutation state as five 64-bit words and applies the 5-bit S-box column-wise (bit-sliced), LANES_PER_CYCLE columns per clock. A mode input selects the forward or the inverse S-box. The block sits between the round-constant stage and the linear-diffusion stage of a round-iterated permutation core and trades area for latency through valid/ready handshakes.

---
 rtl/ascon_ps_seq.sv | 147 ++++++++++++++
 tb/tb_ascon_ps_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ascon_ps_seq.sv
// Iterative Ascon substitution layer: applies the 5-bit S-box (forward or inverse)
// bit-sliced across the 320-bit state, LANES_PER_CYCLE columns per clock.
module ascon_ps_seq #(
  parameter int LANES_PER_CYCLE = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [319:0] S_i,
  input  logic         inv_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [319:0] S_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o,
  output logic [1:0]   o_dbg_state
);

  localparam int NCYC = 64 / LANES_PER_CYCLE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 2 || LANES_PER_CYCLE == 4 ||
        LANES_PER_CYCLE == 8 || LANES_PER_CYCLE == 16 || LANES_PER_CYCLE == 32 ||
        LANES_PER_CYCLE == 64)) begin : g_bad_lanes
    $error("ascon_ps_seq: LANES_PER_CYCLE must be a power of two from 1 to 64");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and S_o is held stable while out_valid_o waits for ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_fsm;
  state_t          w_fsm_next;
  logic [319:0]    r_state;
  logic [319:0]    w_run_state;
  logic [CW-1:0]   r_cnt;
  logic            r_inv;
  logic            w_load;
  logic            w_step;
  logic            w_last;

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    case (x)
      5'h00: sbox_fwd = 5'h04; 5'h01: sbox_fwd = 5'h0b; 5'h02: sbox_fwd = 5'h1f; 5'h03: sbox_fwd = 5'h14;
      5'h04: sbox_fwd = 5'h1a; 5'h05: sbox_fwd = 5'h15; 5'h06: sbox_fwd = 5'h09; 5'h07: sbox_fwd = 5'h02;
      5'h08: sbox_fwd = 5'h1b; 5'h09: sbox_fwd = 5'h05; 5'h0a: sbox_fwd = 5'h08; 5'h0b: sbox_fwd = 5'h12;
      5'h0c: sbox_fwd = 5'h1d; 5'h0d: sbox_fwd = 5'h03; 5'h0e: sbox_fwd = 5'h06; 5'h0f: sbox_fwd = 5'h1c;
      5'h10: sbox_fwd = 5'h1e; 5'h11: sbox_fwd = 5'h13; 5'h12: sbox_fwd = 5'h07; 5'h13: sbox_fwd = 5'h0e;
      5'h14: sbox_fwd = 5'h00; 5'h15: sbox_fwd = 5'h0d; 5'h16: sbox_fwd = 5'h11; 5'h17: sbox_fwd = 5'h18;
      5'h18: sbox_fwd = 5'h10; 5'h19: sbox_fwd = 5'h0c; 5'h1a: sbox_fwd = 5'h01; 5'h1b: sbox_fwd = 5'h19;
      5'h1c: sbox_fwd = 5'h16; 5'h1d: sbox_fwd = 5'h0a; 5'h1e: sbox_fwd = 5'h0f; default: sbox_fwd = 5'h17;
    endcase
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    case (x)
      5'h00: sbox_inv = 5'h14; 5'h01: sbox_inv = 5'h1a; 5'h02: sbox_inv = 5'h07; 5'h03: sbox_inv = 5'h0d;
      5'h04: sbox_inv = 5'h00; 5'h05: sbox_inv = 5'h09; 5'h06: sbox_inv = 5'h0e; 5'h07: sbox_inv = 5'h12;
      5'h08: sbox_inv = 5'h0a; 5'h09: sbox_inv = 5'h06; 5'h0a: sbox_inv = 5'h1d; 5'h0b: sbox_inv = 5'h01;
      5'h0c: sbox_inv = 5'h19; 5'h0d: sbox_inv = 5'h15; 5'h0e: sbox_inv = 5'h13; 5'h0f: sbox_inv = 5'h1e;
      5'h10: sbox_inv = 5'h18; 5'h11: sbox_inv = 5'h16; 5'h12: sbox_inv = 5'h0b; 5'h13: sbox_inv = 5'h11;
      5'h14: sbox_inv = 5'h03; 5'h15: sbox_inv = 5'h05; 5'h16: sbox_inv = 5'h1c; 5'h17: sbox_inv = 5'h1f;
      5'h18: sbox_inv = 5'h17; 5'h19: sbox_inv = 5'h1b; 5'h1a: sbox_inv = 5'h04; 5'h1b: sbox_inv = 5'h08;
      5'h1c: sbox_inv = 5'h0f; 5'h1d: sbox_inv = 5'h0c; 5'h1e: sbox_inv = 5'h10; default: sbox_inv = 5'h02;
    endcase
  endfunction

  assign w_last = (r_cnt == CW'(NCYC - 1));

  always_comb begin
    w_fsm_next  = r_fsm;
    w_load      = 1'b0;
    w_step      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_load     = 1'b1;
          w_fsm_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        w_step = 1'b1;
        if (w_last) w_fsm_next = ST_DONE;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) w_fsm_next = ST_IDLE;
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // Column j gathers bit j of each word, x0 (bits 319:256) as the MSB.
  always_comb begin
    int         col;
    logic [4:0] cin;
    logic [4:0] cout;
    w_run_state = r_state;
    col  = 0;
    cin  = 5'd0;
    cout = 5'd0;
    for (int l = 0; l < LANES_PER_CYCLE; l++) begin
      col  = int'(r_cnt) * LANES_PER_CYCLE + l;
      cin  = {r_state[256 + col], r_state[192 + col], r_state[128 + col],
              r_state[64 + col], r_state[col]};
      cout = r_inv ? sbox_inv(cin) : sbox_fwd(cin);
      w_run_state[256 + col] = cout[4];
      w_run_state[192 + col] = cout[3];
      w_run_state[128 + col] = cout[2];
      w_run_state[64 + col]  = cout[1];
      w_run_state[col]       = cout[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_fsm <= w_fsm_next;
      if (w_load) begin
        r_state <= S_i;
        r_inv   <= inv_i;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_state <= w_run_state;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign S_o         = r_state;
  assign o_dbg_state = r_fsm;

endmodule

// File: tb/tb_ascon_ps_seq.sv
// Directed bench for ascon_ps_seq: three instances (1, 16 and 64 lanes per cycle)
// sharing clock and reset, checked against hand-computed vectors and the S-box tables.
module tb_ascon_ps_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [319:0] s_in      [3];
  logic         inv_in    [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [319:0] s_out     [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [1:0]   dbg_state [3];

  int n_checks = 0;
  int n_fail   = 0;
  int lat_tab [3] = '{64, 4, 1};

  logic [4:0] fwd_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LP = (g == 0) ? 1 : ((g == 1) ? 16 : 64);
    ascon_ps_seq #(.LANES_PER_CYCLE(LP)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .S_i         (s_in[g]),
      .inv_i       (inv_in[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .S_o         (s_out[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .busy_o      (busy[g]),
      .o_dbg_state (dbg_state[g])
    );
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] fwd_model(input logic [319:0] s);
    logic [319:0] r;
    logic [4:0]   c;
    r = s;
    for (int j = 0; j < 64; j++) begin
      c = fwd_t[{s[256 + j], s[192 + j], s[128 + j], s[64 + j], s[j]}];
      {r[256 + j], r[192 + j], r[128 + j], r[64 + j], r[j]} = c;
    end
    return r;
  endfunction

  // Accept one state, measure latency, optionally hold backpressure and inject noise in RUN.
  task automatic run(input int d, input logic [319:0] s, input logic inv,
                     input logic [319:0] exp, input string tag,
                     input int hold, input bit noise, output logic [319:0] res);
    int n;
    logic [319:0] snap;
    @(negedge clk);
    s_in[d] = s; inv_in[d] = inv; in_valid[d] = 1'b1;
    check({tag, "_in_ready"}, 320'(in_ready[d]), 320'(1));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 200) begin
      if (noise) begin
        in_valid[d] = 1'($urandom_range(0, 1));
        inv_in[d]   = 1'($urandom_range(0, 1));
        for (int k = 0; k < 10; k++) s_in[d][k*32 +: 32] = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid[d] = 1'b0;
    check({tag, "_latency"}, 320'(n), 320'(lat_tab[d]));
    check({tag, "_result"}, s_out[d], exp);
    res  = s_out[d];
    snap = s_out[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_bp_data"}, s_out[d], snap);
      check({tag, "_bp_valid"}, 320'(out_valid[d]), 320'(1));
      check({tag, "_bp_in_ready"}, 320'(in_ready[d]), 320'(0));
    end
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check({tag, "_idle_ready"}, 320'(in_ready[d]), 320'(1));
    check({tag, "_idle_valid"}, 320'(out_valid[d]), 320'(0));
  endtask

  initial begin
    logic [319:0] res, rnd, fw;
    for (int d = 0; d < 3; d++) begin
      s_in[d] = '0; inv_in[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 320'(in_ready[d]), 320'(1));
      check("rst_out_valid", 320'(out_valid[d]), 320'(0));
      check("rst_busy", 320'(busy[d]), 320'(0));
      check("rst_s_o", s_out[d], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Column 0x00 -> 0x04: only x2 set.
    run(1, '0, 1'b0, {64'd0, 64'd0, ONES, 64'd0, 64'd0}, "fwd_zero", 0, 0, res);
    // Column 0x1F -> 0x17: all words set except x1.
    run(1, {5{ONES}}, 1'b0, {ONES, 64'd0, ONES, ONES, ONES}, "fwd_ones", 0, 0, res);
    // Column 0x01 -> 0x0B: x1, x3, x4 set.
    run(2, {64'd0, 64'd0, 64'd0, 64'd0, ONES}, 1'b0, {64'd0, ONES, 64'd0, ONES, ONES}, "fwd_x4", 0, 0, res);
    // Inverse column 0x00 -> 0x14: x0, x2 set.
    run(1, '0, 1'b1, {ONES, 64'd0, ONES, 64'd0, 64'd0}, "inv_zero", 0, 0, res);
    // Inverse column 0x1F -> 0x02: only x3 set.
    run(0, {5{ONES}}, 1'b1, {64'd0, 64'd0, 64'd0, ONES, 64'd0}, "inv_ones", 0, 0, res);

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 10; k++) rnd[k*32 +: 32] = $urandom;
      fw = fwd_model(rnd);
      run(d, rnd, 1'b0, fw, "rt_fwd", 0, 0, res);
      run(d, res, 1'b1, rnd, "rt_inv", 0, 0, res);
    end

    for (int k = 0; k < 10; k++) rnd[k*32 +: 32] = $urandom;
    run(1, rnd, 1'b0, fwd_model(rnd), "backpressure", 10, 0, res);

    for (int k = 0; k < 10; k++) rnd[k*32 +: 32] = $urandom;
    run(0, rnd, 1'b0, fwd_model(rnd), "ignored_in", 0, 1, res);

    // Reset while the 16-lane instance sits at cnt==2.
    @(negedge clk);
    s_in[1] = {5{ONES}}; inv_in[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("mid_run_busy", 320'(busy[1]), 320'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 320'(out_valid[1]), 320'(0));
    check("mid_rst_in_ready", 320'(in_ready[1]), 320'(1));
    check("mid_rst_s_o", s_out[1], '0);
    @(negedge clk);
    rst = 1'b0;
    run(1, {64'd0, 64'd0, 64'd0, 64'd0, ONES}, 1'b0, {64'd0, ONES, 64'd0, ONES, ONES}, "post_rst", 0, 0, res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
